// File: rtl/exception_ctrl_if.sv
// Bundle of request, capture and redirect signals between the pipeline and exception_ctrl.
// Optional EXC_COUNT_EN adds the per-source counter read port (cnt_sel/cnt_val).
interface exception_ctrl_if #(
    parameter int NUM_SRC = 4
);
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]   exc_req;
    logic [5*NUM_SRC-1:0] exc_code;
    logic [NUM_SRC-1:0]   exc_mask;
    logic [31:0]          exc_pc;
    logic [31:0]          exc_badaddr;
    logic                 eret;
    logic                 exception;
    logic                 flush;
    logic                 pc_redirect;
    logic [31:0]          redirect_addr;
    logic [31:0]          epc;
    logic [4:0]           cause;
    logic [31:0]          bad_addr;
    logic                 exl;
    logic [NUM_SRC-1:0]   pending;
`ifdef EXC_COUNT_EN
    logic [SEL_W-1:0]     cnt_sel;
    logic [15:0]          cnt_val;
`endif

    modport slave (
        input  exc_req, exc_code, exc_mask, exc_pc, exc_badaddr, eret,
`ifdef EXC_COUNT_EN
        input  cnt_sel,
        output cnt_val,
`endif
        output exception, flush, pc_redirect, redirect_addr,
        output epc, cause, bad_addr, exl, pending
    );

    modport master (
        output exc_req, exc_code, exc_mask, exc_pc, exc_badaddr, eret,
`ifdef EXC_COUNT_EN
        output cnt_sel,
        input  cnt_val,
`endif
        input  exception, flush, pc_redirect, redirect_addr,
        input  epc, cause, bad_addr, exl, pending
    );
endinterface

// File: rtl/exception_ctrl.sv
// Fixed-priority MIPS exception controller: capture, flush, redirect to handler, return on eret.
// Define EXC_COUNT_EN to add saturating per-source taken counters readable through cnt_sel/cnt_val.
module exception_ctrl #(
    parameter int          NUM_SRC      = 4,
    parameter logic [31:0] HANDLER_ADDR = 32'h80000180,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    exception_ctrl_if.slave bus
);
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FLUSH    = 3'd1;
    localparam logic [2:0] ST_REDIRECT = 3'd2;
    localparam logic [2:0] ST_HANDLER  = 3'd3;
    localparam logic [2:0] ST_RETURN   = 3'd4;

    logic [2:0]         r_state;
    logic [3:0]         r_flushCnt;
    logic               r_exception;
    logic               r_flush;
    logic               r_pcRedirect;
    logic [31:0]        r_redirectAddr;
    logic [31:0]        r_epc;
    logic [4:0]         r_cause;
    logic [31:0]        r_badAddr;
    logic               r_exl;
    logic [NUM_SRC-1:0] r_pending;

    logic [NUM_SRC-1:0] w_eff;
    logic [NUM_SRC-1:0] w_newReq;
    logic               w_anyReq;
    logic [SEL_W-1:0]   w_winner;
    logic [4:0]         w_winnerCode;

    // Pended requests compete with live ones; scanning downward leaves the lowest index as winner.
    always_comb begin
        w_eff    = (bus.exc_req | r_pending) & ~bus.exc_mask;
        w_newReq = bus.exc_req & ~bus.exc_mask;
        w_anyReq = |w_eff;
        w_winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_eff[i]) begin
                w_winner = SEL_W'(i);
            end
        end
        w_winnerCode = bus.exc_code[5*w_winner +: 5];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_flushCnt     <= '0;
            r_exception    <= 1'b0;
            r_flush        <= 1'b0;
            r_pcRedirect   <= 1'b0;
            r_redirectAddr <= '0;
            r_epc          <= '0;
            r_cause        <= '0;
            r_badAddr      <= '0;
            r_exl          <= 1'b0;
            r_pending      <= '0;
        end else begin
            r_exception <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_anyReq) begin
                        r_exception         <= 1'b1;
                        r_flush             <= 1'b1;
                        r_epc               <= bus.exc_pc;
                        r_cause             <= w_winnerCode;
                        r_badAddr           <= bus.exc_badaddr;
                        r_pending[w_winner] <= 1'b0;
                        r_flushCnt          <= 4'(FLUSH_CYCLES);
                        r_state             <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // The last flush cycle hands straight over to the redirect strobe.
                    if (r_flushCnt <= 4'd1) begin
                        r_flushCnt     <= '0;
                        r_pcRedirect   <= 1'b1;
                        r_redirectAddr <= HANDLER_ADDR;
                        r_exl          <= 1'b1;
                        r_state        <= ST_REDIRECT;
                    end else begin
                        r_flushCnt <= r_flushCnt - 4'd1;
                    end
                end
                ST_REDIRECT: begin
                    r_pcRedirect <= 1'b0;
                    r_flush      <= 1'b0;
                    r_state      <= ST_HANDLER;
                end
                ST_HANDLER: begin
                    if (bus.eret) begin
                        r_pcRedirect   <= 1'b1;
                        r_redirectAddr <= r_epc;
                        r_exl          <= 1'b0;
                        r_state        <= ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    r_pcRedirect <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_flush      <= 1'b0;
                    r_pcRedirect <= 1'b0;
                    r_exl        <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
            if (r_state != ST_IDLE) begin
                r_pending <= r_pending | w_newReq;
            end
        end
    end

`ifdef EXC_COUNT_EN
    logic [15:0] r_excCnt [NUM_SRC];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_excCnt[i] <= '0;
            end
        end else if (r_state == ST_IDLE && w_anyReq && r_excCnt[w_winner] != 16'hFFFF) begin
            r_excCnt[w_winner] <= r_excCnt[w_winner] + 16'd1;
        end
    end

    always_comb begin
        bus.cnt_val = '0;
        if (int'(bus.cnt_sel) < NUM_SRC) begin
            bus.cnt_val = r_excCnt[bus.cnt_sel];
        end
    end
`endif

    assign bus.exception     = r_exception;
    assign bus.flush         = r_flush;
    assign bus.pc_redirect   = r_pcRedirect;
    assign bus.redirect_addr = r_redirectAddr;
    assign bus.epc           = r_epc;
    assign bus.cause         = r_cause;
    assign bus.bad_addr      = r_badAddr;
    assign bus.exl           = r_exl;
    assign bus.pending       = r_pending;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl with a scoreboard of expected captures (EPC/cause/BadVAddr).
// Counter checks are compiled in when EXC_COUNT_EN is defined.
module tb_exception_ctrl;
    localparam int          NUM_SRC  = 4;
    localparam logic [31:0] HANDLER  = 32'h80000180;
    localparam int          FLUSH_CY = 2;

    typedef struct {
        logic [31:0] epc;
        logic [4:0]  cause;
        logic [31:0] badAddr;
    } expEntry_t;

    logic       clk;
    logic       rst_n;
    int         vecCount;
    int         missCount;
    expEntry_t  sbQueue [$];
    logic [4:0] codeTab [NUM_SRC] = '{5'h04, 5'h05, 5'h0C, 5'h1F};

    exception_ctrl_if #(.NUM_SRC(NUM_SRC)) bus ();

    exception_ctrl #(
        .NUM_SRC     (NUM_SRC),
        .HANDLER_ADDR(HANDLER),
        .FLUSH_CYCLES(FLUSH_CY)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Inputs are driven at a falling edge, held across one rising edge, then dropped.
    task automatic applyStimulus(input logic [NUM_SRC-1:0] req, input logic eretIn);
        bus.exc_req = req;
        bus.eret    = eretIn;
        @(negedge clk);
        bus.exc_req = '0;
        bus.eret    = 1'b0;
    endtask

    task automatic pushExpect(input int src);
        expEntry_t e;
        e.epc     = bus.exc_pc;
        e.cause   = codeTab[src];
        e.badAddr = bus.exc_badaddr;
        sbQueue.push_back(e);
    endtask

    task automatic expectEntry(input string tag, input int budget);
        expEntry_t e;
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (bus.exception === 1'b1) seen = 1;
            else @(negedge clk);
        end
        if (!seen && bus.exception === 1'b1) seen = 1;
        checkOutput({tag, "_taken"}, 32'(seen), 32'd1);
        if (seen) begin
            checkOutput({tag, "_sb_nonempty"}, 32'(sbQueue.size() > 0), 32'd1);
            if (sbQueue.size() > 0) begin
                e = sbQueue.pop_front();
                checkOutput({tag, "_epc"}, bus.epc, e.epc);
                checkOutput({tag, "_cause"}, 32'(bus.cause), 32'(e.cause));
                checkOutput({tag, "_badaddr"}, bus.bad_addr, e.badAddr);
            end
        end
    endtask

    task automatic checkEntrySequence(input string tag);
        for (int k = 0; k < FLUSH_CY; k++) begin
            checkOutput({tag, "_flush_phase"}, 32'({bus.flush, bus.pc_redirect}), 32'b10);
            @(negedge clk);
        end
        checkOutput({tag, "_redirect"}, 32'({bus.pc_redirect, bus.flush, bus.exl}), 32'b111);
        checkOutput({tag, "_redirect_addr"}, bus.redirect_addr, HANDLER);
        @(negedge clk);
        checkOutput({tag, "_handler"}, 32'({bus.pc_redirect, bus.flush, bus.exl}), 32'b001);
    endtask

    task automatic doEret(input string tag, input logic [31:0] expEpc);
        applyStimulus('0, 1'b1);
        checkOutput({tag, "_return_strobe"}, 32'({bus.pc_redirect, bus.exl}), 32'b10);
        checkOutput({tag, "_return_addr"}, bus.redirect_addr, expEpc);
        @(negedge clk);
        checkOutput({tag, "_return_done"}, 32'(bus.pc_redirect), 32'd0);
    endtask

    initial begin
        bit sawBad;
        vecCount         = 0;
        missCount        = 0;
        rst_n            = 1'b0;
        bus.exc_req      = '0;
        bus.exc_mask     = '0;
        bus.exc_code     = {codeTab[3], codeTab[2], codeTab[1], codeTab[0]};
        bus.exc_pc       = '0;
        bus.exc_badaddr  = '0;
        bus.eret         = 1'b0;
`ifdef EXC_COUNT_EN
        bus.cnt_sel      = '0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", 32'({bus.exception, bus.flush, bus.pc_redirect, bus.exl}), 32'd0);
        checkOutput("reset_capture", bus.epc | bus.bad_addr | 32'(bus.cause), 32'd0);
        checkOutput("reset_pending", 32'(bus.pending), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single request, source 2");
        bus.exc_pc = 32'h0040_0010; bus.exc_badaddr = 32'h0000_1234;
        pushExpect(2);
        applyStimulus(4'b0100, 1'b0);
        expectEntry("t1", 1);
        checkEntrySequence("t1");
        checkOutput("t1_pending", 32'(bus.pending), 32'd0);
        doEret("t1", 32'h0040_0010);

        $display("[TB] simultaneous requests 1 and 3");
        bus.exc_pc = 32'h0040_0200; bus.exc_badaddr = 32'h0000_BEEF;
        pushExpect(1);
        applyStimulus(4'b1010, 1'b0);
        expectEntry("t2", 1);
        checkOutput("t2_no_pend_loser", 32'(bus.pending), 32'd0);
        checkEntrySequence("t2");

        $display("[TB] request while in handler");
        applyStimulus(4'b1000, 1'b0);
        checkOutput("t3_pended", 32'({bus.pending, bus.exception}), 32'b1000_0);
        bus.exc_pc = 32'h0040_0300; bus.exc_badaddr = 32'h0000_0300;
        pushExpect(3);
        doEret("t3", 32'h0040_0200);
        expectEntry("t3", 2);
        checkOutput("t3_pending_cleared", 32'(bus.pending), 32'd0);
        checkEntrySequence("t3");

        $display("[TB] eret and request in the same handler cycle");
        bus.exc_pc = 32'h0040_0400; bus.exc_badaddr = 32'h0000_0400;
        pushExpect(0);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("t4_return_first", 32'({bus.pc_redirect, bus.exception}), 32'b10);
        checkOutput("t4_return_addr", bus.redirect_addr, 32'h0040_0300);
        checkOutput("t4_pended", 32'(bus.pending), 32'b0001);
        @(negedge clk);
        checkOutput("t4_idle_gap", 32'(bus.exception), 32'd0);
        @(negedge clk);
        expectEntry("t4", 1);
        checkEntrySequence("t4");
        doEret("t4", 32'h0040_0400);

        $display("[TB] reset during flush");
        bus.exc_pc = 32'h0040_0500;
        applyStimulus(4'b0100, 1'b0);
        checkOutput("t5_taken", 32'(bus.exception), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_async_clear", 32'({bus.flush, bus.pc_redirect, bus.exl, bus.exception}), 32'd0);
        checkOutput("t5_capture_clear", bus.epc | 32'(bus.cause), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        sawBad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.pc_redirect !== 1'b0 || bus.exception !== 1'b0) sawBad = 1;
        end
        checkOutput("t5_no_redirect", 32'(sawBad), 32'd0);

        $display("[TB] masked request");
        bus.exc_mask = 4'b0001;
        bus.exc_req  = 4'b0001;
        sawBad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.exception !== 1'b0) sawBad = 1;
        end
        bus.exc_req = '0;
        checkOutput("t6_masked_no_exc", 32'(sawBad), 32'd0);
        checkOutput("t6_masked_no_pend", 32'(bus.pending), 32'd0);
        bus.exc_mask = '0;
        @(negedge clk);

        $display("[TB] pended source masked until released");
        bus.exc_pc = 32'h0040_0700; bus.exc_badaddr = 32'h0000_0700;
        pushExpect(2);
        applyStimulus(4'b0100, 1'b0);
        expectEntry("t7", 1);
        checkEntrySequence("t7");
        applyStimulus(4'b0010, 1'b0);
        bus.exc_mask = 4'b0010;
        doEret("t7", 32'h0040_0700);
        sawBad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.exception !== 1'b0) sawBad = 1;
        end
        checkOutput("t7_masked_pend_held", 32'({sawBad, bus.pending}), 32'b0_0010);
        bus.exc_pc = 32'h0040_0800; bus.exc_badaddr = 32'h0000_0800;
        pushExpect(1);
        bus.exc_mask = '0;
        expectEntry("t7u", 2);
        checkOutput("t7u_pending_cleared", 32'(bus.pending), 32'd0);
        checkEntrySequence("t7u");
        doEret("t7u", 32'h0040_0800);

`ifdef EXC_COUNT_EN
        $display("[TB] per-source counters");
        for (int n = 0; n < 2; n++) begin
            bus.exc_pc = 32'h0040_0900 + 32'(n);
            pushExpect(2);
            applyStimulus(4'b0100, 1'b0);
            expectEntry("cnt", 1);
            checkEntrySequence("cnt");
            doEret("cnt", 32'h0040_0900 + 32'(n));
        end
        bus.cnt_sel = 2'd2;
        #1 checkOutput("cnt_src2", 32'(bus.cnt_val), 32'd3);
        bus.cnt_sel = 2'd1;
        #1 checkOutput("cnt_src1", 32'(bus.cnt_val), 32'd1);
        bus.cnt_sel = 2'd0;
        #1 checkOutput("cnt_src0", 32'(bus.cnt_val), 32'd0);
`endif

        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
